// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side request/response and memory-side req/ack bundle for mem_port_arbiter.
// Perf counter outputs exist only when MEM_ARB_PERF_EN is defined.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
`ifdef MEM_ARB_PERF_EN
    logic [31:0]       perf_stall_cycles;
    logic [31:0]       perf_if_discards;
`endif

    modport master (
        input  if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        output if_rdata, if_done, d_rdata, d_done, stall, mem_req, mem_we, mem_addr, mem_wdata
`ifdef MEM_ARB_PERF_EN
        , output perf_stall_cycles, perf_if_discards
`endif
    );

    modport slave (
        output if_req, if_addr, if_flush, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_done, d_rdata, d_done, stall, mem_req, mem_we, mem_addr, mem_wdata
`ifdef MEM_ARB_PERF_EN
        , input perf_stall_cycles, perf_if_discards
`endif
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory port between IF fetch and MEM load/store, data first.
// Define MEM_ARB_PERF_EN to add saturating stall-cycle and discarded-fetch counters.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    mem_port_arbiter_if.master  bus
);
    typedef enum logic [1:0] {IDLE, D_BUSY, I_BUSY, RESP} state_e;

    state_e            state_q;
    logic              mem_req_q, mem_we_q, if_done_q, d_done_q, discard_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q, if_rdata_q, d_rdata_q;
    logic              stall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.d_req) begin
                        state_q     <= D_BUSY;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.d_we;
                        mem_addr_q  <= bus.d_addr;
                        mem_wdata_q <= bus.d_wdata;
                    end else if (bus.if_req && !bus.if_flush) begin
                        state_q    <= I_BUSY;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= bus.if_addr;
                    end
                end
                D_BUSY: begin
                    if (bus.mem_ack) begin
                        state_q   <= RESP;
                        mem_req_q <= 1'b0;
                        d_done_q  <= 1'b1;
                        if (!mem_we_q) d_rdata_q <= bus.mem_rdata;
                    end
                end
                I_BUSY: begin
                    // The transaction always runs to completion; a flush only hides its result.
                    if (bus.if_flush) discard_q <= 1'b1;
                    if (bus.mem_ack) begin
                        state_q   <= RESP;
                        mem_req_q <= 1'b0;
                        if (!discard_q && !bus.if_flush) begin
                            if_rdata_q <= bus.mem_rdata;
                            if_done_q  <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state_q   <= IDLE;
                    discard_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // A discarded fetch raises no done, so its RESP cycle keeps the pipeline frozen.
    assign stall = (bus.d_req & ~d_done_q) | (bus.if_req & ~if_done_q) |
                   ((state_q != IDLE) & ~((state_q == RESP) & (d_done_q | if_done_q)));

    assign bus.stall     = stall;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_done    = d_done_q;

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_disc_q, perf_disc_d;

    always_comb begin
        perf_stall_d = perf_stall_q;
        perf_disc_d  = perf_disc_q;
        if (stall && (perf_stall_q != 32'hFFFF_FFFF))
            perf_stall_d = perf_stall_q + 32'd1;
        if ((state_q == RESP) && discard_q && (perf_disc_q != 32'hFFFF_FFFF))
            perf_disc_d = perf_disc_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_stall_q <= '0;
            perf_disc_q  <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_disc_q  <= perf_disc_d;
        end
    end

    assign bus.perf_stall_cycles = perf_stall_q;
    assign bus.perf_if_discards  = perf_disc_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle corner sequences,
// then randomized traffic checked against transaction-level rules.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory contents as seen by the responder and by the reference model.
    function automatic logic [31:0] init_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'h8C01_0004 : ((a ^ 32'hA5A5_0000) + 32'h13);
    endfunction

    logic [31:0] mem_a [logic [31:0]];
    logic [31:0] ref_a [logic [31:0]];

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_a.exists(a) ? ref_a[a] : init_val(a);
    endfunction

    // Memory responder: ack after lat_cfg (or random 0..3) extra cycles of mem_req.
    bit mem_en = 1'b1;
    bit rnd_lat = 1'b0;
    bit force_ack = 1'b0;
    int lat_cfg = 0;
    initial begin
        int cnt, cur_lat;
        logic ack;
        cnt = 0;
        cur_lat = 0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            ack = force_ack;
            if (mem_en && bus.mem_req) begin
                if (cnt == 0) cur_lat = rnd_lat ? int'($urandom_range(0, 3)) : lat_cfg;
                if (cnt >= cur_lat) begin
                    ack = 1'b1;
                    cnt = 0;
                    if (bus.mem_we) mem_a[bus.mem_addr] = bus.mem_wdata;
                    else bus.mem_rdata = mem_a.exists(bus.mem_addr) ? mem_a[bus.mem_addr] : init_val(bus.mem_addr);
                end else cnt++;
            end else cnt = 0;
            bus.mem_ack = ack;
        end
    end

`ifdef MEM_ARB_PERF_EN
    int stall_cnt = 0;
    always @(negedge clk) begin
        if (!reset_n) stall_cnt = 0;
        else if (bus.stall) stall_cnt++;
    end
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        int          exp_cyc;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [6];
    logic [31:0] exp_drd, exp_ird;

    initial begin
        vec_t v;
        int cyc, k;
        bit dn;
        logic [6:0]  dd, id7, st7, mr7;
        logic [11:0] id12, st12;
        logic [15:0] mask;
        logic [31:0] ma1, ma4, ird4, irdd;

        tbl[0] = '{1'b0, 1'b0, 32'h10, 32'h0, 2, 5, 32'h8C01_0004};
        tbl[1] = '{1'b1, 1'b0, 32'h44, 32'h0, 1, 4, 32'hA5A5_0057};
        tbl[2] = '{1'b1, 1'b1, 32'h20, 32'hDEAD_BEEF, 4, 7, 32'h0};
        tbl[3] = '{1'b1, 1'b0, 32'h20, 32'h0, 0, 3, 32'hDEAD_BEEF};
        tbl[4] = '{1'b0, 1'b0, 32'h14, 32'h0, 0, 3, 32'hA5A5_0027};
        tbl[5] = '{1'b0, 1'b0, 32'h18, 32'h0, 3, 6, 32'hA5A5_002B};

        reset_n = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = '0; bus.if_flush = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        exp_drd = '0; exp_ird = '0;

        // Reset state
        @(negedge clk);
        chk("rst_mem", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, '0);
        chk("rst_rdata", {bus.if_rdata, bus.d_rdata}, '0);
        chk("rst_done", {bus.if_done, bus.d_done}, '0);
        tick();
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        chk("idle_stall", bus.stall, 1'b0);
        tick();

        // Single transactions from the table
        for (int i = 0; i < 6; i++) begin
            v = tbl[i];
            lat_cfg = v.lat;
            if (v.is_d) begin
                bus.d_req = 1'b1; bus.d_we = v.we; bus.d_addr = v.addr; bus.d_wdata = v.wdata;
            end else begin
                bus.if_req = 1'b1; bus.if_addr = v.addr;
            end
            cyc = 0;
            dn = 1'b0;
            while (!dn && cyc < 40) begin
                @(negedge clk);
                dn = v.is_d ? bus.d_done : bus.if_done;
                cyc++;
                chk($sformatf("t%0d_stall", i), bus.stall, !dn);
                if (bus.mem_req)
                    chk($sformatf("t%0d_memfld", i), {bus.mem_addr, bus.mem_we, (v.we ? bus.mem_wdata : 32'h0)},
                        {v.addr, v.we, (v.we ? v.wdata : 32'h0)});
                tick();
            end
            bus.d_req = 1'b0;
            bus.if_req = 1'b0;
            chk($sformatf("t%0d_cycles", i), cyc, v.exp_cyc);
            if (v.is_d) begin
                if (!v.we) exp_drd = v.exp_rd;
                chk($sformatf("t%0d_drdata", i), bus.d_rdata, exp_drd);
            end else begin
                exp_ird = v.exp_rd;
                chk($sformatf("t%0d_irdata", i), bus.if_rdata, exp_ird);
            end
            tick();
        end

        // Load and fetch collide: data first, fetch right after RESP
        lat_cfg = 0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h40;
        bus.if_req = 1'b1; bus.if_addr = 32'h14;
        ma1 = '0; ma4 = '0;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            dd[c] = bus.d_done; id7[c] = bus.if_done; st7[c] = bus.stall; mr7[c] = bus.mem_req;
            if (c == 1) ma1 = bus.mem_addr;
            if (c == 4) ma4 = bus.mem_addr;
            tick();
            if (dd[c]) bus.d_req = 1'b0;
            if (id7[c]) bus.if_req = 1'b0;
        end
        chk("col_d_done", dd, 7'b0000100);
        chk("col_if_done", id7, 7'b0100000);
        chk("col_stall", st7, 7'b0011111);
        chk("col_mem_req", mr7, 7'b0010010);
        chk("col_addrs", {ma1, ma4}, {32'h40, 32'h14});
        chk("col_d_rdata", bus.d_rdata, 32'hA5A5_0053);
        chk("col_if_rdata", bus.if_rdata, 32'hA5A5_0027);
        exp_ird = 32'hA5A5_0027;
        tick();

        // Flush during a fetch, then redirected fetch at 0x100
        lat_cfg = 2;
        bus.if_req = 1'b1; bus.if_addr = 32'h30;
        ird4 = '0; irdd = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            id12[c] = bus.if_done; st12[c] = bus.stall;
            if (c == 4) ird4 = bus.if_rdata;
            if (bus.if_done) irdd = bus.if_rdata;
            tick();
            if (c == 1) begin bus.if_flush = 1'b1; bus.if_addr = 32'h100; end
            if (c == 2) bus.if_flush = 1'b0;
            if (id12[c]) bus.if_req = 1'b0;
        end
        chk("fl_if_done", id12, 12'h200);
        chk("fl_stall", st12, 12'h1FF);
        chk("fl_rdata_kept", ird4, exp_ird);
        chk("fl_refetch", irdd, 32'hA5A5_0113);
`ifdef MEM_ARB_PERF_EN
        chk("perf_discards", bus.perf_if_discards, 32'd1);
        chk("perf_stall_a", bus.perf_stall_cycles, stall_cnt);
`endif
        tick();

        // Five zero-latency fetches back to back
        lat_cfg = 0;
        k = 0;
        mask = '0;
        bus.if_req = 1'b1; bus.if_addr = 32'h200;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            dn = bus.if_done;
            if (dn) begin
                mask[c] = 1'b1;
                chk($sformatf("b2b_data%0d", k), bus.if_rdata, init_val(32'h200 + 32'(4 * k)));
                k++;
            end
            tick();
            if (dn) begin
                if (k < 5) bus.if_addr = 32'h200 + 32'(4 * k);
                else bus.if_req = 1'b0;
            end
        end
        chk("b2b_done_cycles", mask, 16'h4924);
        tick();

        // Reset in the middle of a data transaction, then a stray ack
        mem_en = 1'b0;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h48;
        tick();
        tick();
        @(negedge clk);
        chk("rmo_busy", bus.mem_req, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rmo_mem", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, '0);
        chk("rmo_out", {bus.if_rdata, bus.d_rdata, bus.if_done, bus.d_done}, '0);
        bus.d_req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("rmo_stray%0d", c), {bus.mem_req, bus.d_done, bus.if_done, bus.stall}, 4'b0);
            tick();
        end
        mem_en = 1'b1;
        exp_drd = '0;

        // Randomized traffic against transaction-level rules
        begin
            bit d_seen, i_seen, pend;
            int d_wait, i_wait;
            logic p_mreq, p_ack, pp_ack, p_we, p_dreq, p_dwe, p_ireq, p_flush;
            logic [31:0] p_addr, p_wd, p_daddr, p_dwd, p_iaddr;
            d_seen = 0; i_seen = 0; d_wait = 0; i_wait = 0;
            p_mreq = 0; p_ack = 0; pp_ack = 0; p_we = 0; p_dreq = 0; p_dwe = 0; p_ireq = 0; p_flush = 0;
            p_addr = '0; p_wd = '0; p_daddr = '0; p_dwd = '0; p_iaddr = '0;
            rnd_lat = 1'b1;
            for (int c = 0; c < 4000; c++) begin
                bus.if_flush = 1'b0;
                if (d_seen) begin bus.d_req = 1'b0; d_seen = 0; end
                if (i_seen) begin bus.if_req = 1'b0; i_seen = 0; end
                if (!bus.d_req && $urandom_range(0, 5) == 0) begin
                    bus.d_req = 1'b1; bus.d_we = 1'($urandom_range(0, 1));
                    bus.d_addr = 32'h2000 + 32'(4 * $urandom_range(0, 15));
                    bus.d_wdata = $urandom; d_wait = 0;
                end
                if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                    bus.if_req = 1'b1; bus.if_addr = 32'h1000 + 32'(4 * $urandom_range(0, 63)); i_wait = 0;
                end else if (bus.if_req && !bus.if_done && $urandom_range(0, 9) == 0) begin
                    bus.if_flush = 1'b1; bus.if_addr = 32'h1000 + 32'(4 * $urandom_range(0, 63)); i_wait = 0;
                end
                @(negedge clk);
                pend = (bus.d_req & ~bus.d_done) | (bus.if_req & ~bus.if_done) | bus.mem_req;
                if (pend) chk("r_stall", bus.stall, 1'b1);
                if (p_mreq && !p_ack)
                    chk("r_hold", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata}, {1'b1, p_we, p_addr, p_wd});
                else if (p_mreq && p_ack)
                    chk("r_drop", bus.mem_req, 1'b0);
                else if (bus.mem_req) begin
                    chk("r_gap", pp_ack, 1'b0);
                    if (p_dreq)
                        chk("r_gnt_d", {bus.mem_we, bus.mem_addr, (bus.mem_we ? bus.mem_wdata : 32'h0)},
                            {p_dwe, p_daddr, (p_dwe ? p_dwd : 32'h0)});
                    else
                        chk("r_gnt_i", {p_ireq & ~p_flush, bus.mem_we, bus.mem_addr}, {1'b1, 1'b0, p_iaddr});
                end
                if (bus.d_done) begin
                    chk("r_d_pend", bus.d_req, 1'b1);
                    if (bus.d_we) begin
                        chk("r_st_rdata", bus.d_rdata, exp_drd);
                        ref_a[bus.d_addr] = bus.d_wdata;
                    end else begin
                        exp_drd = ref_rd(bus.d_addr);
                        chk("r_ld_rdata", bus.d_rdata, exp_drd);
                    end
                    d_seen = 1;
                end
                if (bus.if_done) begin
                    chk("r_i_pend", bus.if_req, 1'b1);
                    chk("r_if_rdata", bus.if_rdata, ref_rd(bus.if_addr));
                    i_seen = 1;
                end
                if (bus.d_req) d_wait++;
                if (bus.if_req) i_wait++;
                if (d_wait > 40) begin chk("r_d_timeout", d_wait, 40); bus.d_req = 1'b0; d_wait = 0; end
                if (i_wait > 200) begin chk("r_i_timeout", i_wait, 200); bus.if_req = 1'b0; i_wait = 0; end
                pp_ack = p_ack; p_ack = bus.mem_ack; p_mreq = bus.mem_req; p_we = bus.mem_we;
                p_addr = bus.mem_addr; p_wd = bus.mem_wdata;
                p_dreq = bus.d_req; p_dwe = bus.d_we; p_daddr = bus.d_addr; p_dwd = bus.d_wdata;
                p_ireq = bus.if_req; p_flush = bus.if_flush; p_iaddr = bus.if_addr;
                tick();
            end
        end
        bus.d_req = 1'b0; bus.if_req = 1'b0; bus.if_flush = 1'b0;
        for (int c = 0; c < 12; c++) tick();
        @(negedge clk);
        chk("end_idle", {bus.mem_req, bus.stall}, 2'b00);
        tick();
`ifdef MEM_ARB_PERF_EN
        chk("perf_stall_b", bus.perf_stall_cycles, stall_cnt);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single shared instruction/data memory port between the pipeline's IF stage (instruction fetch) and MEM stage (load/store).
- Grants one requester at a time and drives a variable-latency req/ack memory interface.
- Generates the global pipeline stall.
- Honours IF_Flush by discarding in-flight fetch data.

Parameters:
ADDR_W  32  address width
DATA_W  32  data width

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
if_req  in  1  IF fetch request, level, held until if_done
if_addr  in  ADDR_W  fetch address (PC)
if_flush  in  1  IF_Flush from branch/jump resolution
if_rdata  out  DATA_W  fetched instruction
if_done  out  1  one-cycle fetch-complete pulse
d_req  in  1  MEM-stage request, level, held until d_done
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address (ALU_result_MEM)
d_wdata  in  DATA_W  store data (Read_Data_2_MEM)
d_rdata  out  DATA_W  load data
d_done  out  1  one-cycle data-complete pulse
stall  out  1  freeze PC and all pipeline registers
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_ack
mem_ack  in  1  memory completion, one cycle

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, if_done, d_done. Discard flag cleared.
  - Reset mid-transaction drops mem_req immediately. A later stray mem_ack is ignored in IDLE.
- States:
  - IDLE: no transaction.
  - D_BUSY: data transaction in flight.
  - I_BUSY: fetch transaction in flight.
  - RESP: response cycle, done pulse driven.
- IDLE:
  - d_req=1 -> D_BUSY. Register mem_addr=d_addr, mem_we=d_we, mem_wdata=d_wdata, mem_req=1.
  - Else if_req=1 and if_flush=0 -> I_BUSY. Register mem_addr=if_addr, mem_we=0, mem_req=1.
  - Data has fixed priority over IF: MEM holds the older instruction.
- D_BUSY / I_BUSY:
  - mem_req, mem_addr, mem_we and mem_wdata are held stable until mem_ack is sampled 1.
  - On mem_ack: mem_req=0 next cycle and state -> RESP.
  - Load or fetch captures mem_rdata into d_rdata or if_rdata.
  - mem_ack may arrive in the first cycle mem_req is high.
- Flush in I_BUSY:
  - if_flush=1 in any I_BUSY cycle, including the ack cycle, sets the discard flag.
  - The memory transaction still completes; memory transactions are not aborted.
  - On completion: if_rdata is not updated and if_done is suppressed in RESP. The flag clears on leaving RESP.
  - if_flush in D_BUSY, RESP or IDLE-without-grant has no effect on the arbiter.
- RESP:
  - Exactly one cycle. Pulse d_done or if_done (unless discarded). No new grant this cycle, then -> IDLE.
  - This blocks re-granting a request whose req is still high on the completion edge.
- Latency: request seen in IDLE at cycle t -> mem_req at t+1 -> ack at t+1+L (L>=0) -> done at t+2+L. Minimum 3 cycles.
- stall (combinational): (d_req & ~d_done) | (if_req & ~if_done).
  - Also asserted whenever state != IDLE, except in RESP when the pending requester's done is high.
- Simultaneous if_req and d_req: data served first, IF served after RESP. stall stays high throughout.
- Address/data are never modified while mem_req=1.

Optional Feature:
- Macro: MEM_ARB_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cycles (32 bits) and perf_if_discards (32 bits).
  - perf_stall_cycles increments every cycle stall=1.
  - perf_if_discards increments on each RESP with the discard flag set.
  - Both reset to 0, saturate at 0xFFFFFFFF, no wrap.
- Not defined: the ports and counters do not exist. Arbitration behaviour is identical.

Test Plan:
- Fetch: if_req=1, if_addr=0x00000010, mem returns 0x8C010004 with L=2 -> mem_req high cycles 1-3, if_done pulse cycle 4, if_rdata=0x8C010004, stall high cycles 0-3 and low in cycle 4.
- Load vs fetch collision: d_req (load 0x40) and if_req (0x14) asserted together, L=0 -> data granted first, d_done cycle 2 with d_rdata=mem value; IF granted cycle 3, if_done cycle 5.
- Store: d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF, ack after 4 cycles -> mem_we=1, mem_wdata stable all 5 cycles, d_done once, d_rdata unchanged.
- Flush: if_flush pulsed in I_BUSY cycle 2, ack cycle 3 -> if_done never asserted, if_rdata unchanged; next if_req (0x100) fetched normally. With MEM_ARB_PERF_EN, perf_if_discards=1.
- Reset mid-op: reset_n low in D_BUSY -> mem_req=0 asynchronously, all outputs 0; mem_ack pulsed after release is ignored, no done pulse.
- Zero-latency back-to-back: five fetches with ack in the first mem_req cycle -> each completes in exactly 3 cycles, no lost or duplicated if_done.
